// File: rtl/dcmi_frame_packer_pkg.sv
// Shared definitions for the DCMI frame packer: FSM states, header size, bus idle value.
// DCMI_PACK_CSUM_EN adds the trailing checksum state and byte.
package dcmi_frame_packer_pkg;

  localparam int unsigned HdrBytes = 2;
`ifdef DCMI_PACK_CSUM_EN
  localparam int unsigned CsumBytes = 1;
`else
  localparam int unsigned CsumBytes = 0;
`endif

  // The bus is OR-combined in the gate, so a non-granted master must drive zero.
  localparam logic [7:0] MdataIdle = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHdrLo,
    StHdrHi,
    StPayload
`ifdef DCMI_PACK_CSUM_EN
    ,
    StCsum
`endif
  } state_e;

endpackage

// File: rtl/dcmi_frame_packer_if.sv
// IOPort8 write side plus DCMI gate handshake of the frame packer.
// master: the packer itself; slave: the IOPort8/gate environment driving it.
interface dcmi_frame_packer_if;
  logic [7:0] di;      // IOPort8 DO
  logic       wr;      // IOPort8 STRB
  logic       clr;     // IOPort8 STRT, buffer clear
  logic       start;   // IOPort8 DONE, send request
  logic [7:0] mdata;
  logic       dclken;
  logic       dreq;
  logic       dack;
  logic       busy;
  logic       ovf;

  modport master (
    input  di, wr, clr, start, dclken, dack,
    output mdata, dreq, busy, ovf
  );

  modport slave (
    output di, wr, clr, start, dclken, dack,
    input  mdata, dreq, busy, ovf
  );
endinterface

// File: rtl/dcmi_pack_ram.sv
// Simple dual-port payload buffer: synchronous write, registered synchronous read.
module dcmi_pack_ram #(
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [2**AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dcmi_frame_packer.sv
// Buffers IOPort8 bytes and sends them as one length-prefixed frame on the DCMI master bus.
// Define DCMI_PACK_CSUM_EN to append an 8-bit sum of header and payload bytes.
module dcmi_frame_packer
  import dcmi_frame_packer_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  dcmi_frame_packer_if.master bus
);

  localparam logic [AW:0] DepthCnt = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   rptr_q, rptr_d;   // payload bytes already loaded onto mdata
  logic [AW-1:0] wptr_q, wptr_d;
  logic [7:0]    mdata_q, mdata_d;
  logic          mvalid_q, mvalid_d;
  logic          dreq_q, dreq_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic [15:0]   len16;
  logic          in_frame, drop, reload, take, fin;
`ifdef DCMI_PACK_CSUM_EN
  logic [7:0]    csum_q, csum_d, csum_sum;

  assign csum_sum = csum_q + mdata_q;
`endif

  assign len16    = 16'(len_q);
  assign in_frame = (state_q != StIdle) && (state_q != StReq);
  assign drop     = !bus.dack;
  // mdata is registered, so after a fresh grant the current byte needs one cycle to reappear.
  assign reload   = bus.dack && !mvalid_q;
  assign take     = bus.dack && mvalid_q && bus.dclken;

  dcmi_pack_ram #(
    .AW(AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.di),
    .raddr_i (rptr_d[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    dreq_d   = dreq_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    ram_we   = 1'b0;
    fin      = 1'b0;
`ifdef DCMI_PACK_CSUM_EN
    csum_d   = csum_q;
    if (in_frame && take) begin
      csum_d = csum_sum;
    end
`endif

    if (state_q != StIdle && bus.wr) begin
      ovf_d = 1'b1;
    end

    if (in_frame) begin
      if (drop) begin
        mdata_d  = MdataIdle;
        mvalid_d = 1'b0;
      end else begin
        mvalid_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.clr) begin
          count_d = '0;
          wptr_d  = '0;
          ovf_d   = 1'b0;
        end else if (bus.wr) begin
          if (count_q == DepthCnt) begin
            ovf_d = 1'b1;
          end else begin
            ram_we  = 1'b1;
            count_d = count_q + 1'b1;
            wptr_d  = wptr_q + 1'b1;
          end
        end
        if (bus.start && !bus.clr && count_d != '0) begin
          len_d   = count_d;
          busy_d  = 1'b1;
          dreq_d  = 1'b1;
          state_d = StReq;
`ifdef DCMI_PACK_CSUM_EN
          csum_d  = '0;
`endif
        end
      end

      StReq: begin
        if (bus.dack) begin
          mdata_d  = len16[7:0];
          mvalid_d = 1'b1;
          state_d  = StHdrLo;
        end
      end

      StHdrLo: begin
        if (reload) begin
          mdata_d = len16[7:0];
        end else if (take) begin
          mdata_d = len16[15:8];
          state_d = StHdrHi;
        end
      end

      StHdrHi: begin
        if (reload) begin
          mdata_d = len16[15:8];
        end else if (take) begin
          mdata_d = ram_rdata;
          rptr_d  = rptr_q + 1'b1;
          state_d = StPayload;
        end
      end

      StPayload: begin
        if (drop) begin
          // Step back so the unsent byte is re-read from the buffer on resume.
          if (mvalid_q) begin
            rptr_d = rptr_q - 1'b1;
          end
        end else if (reload) begin
          mdata_d = ram_rdata;
          rptr_d  = rptr_q + 1'b1;
        end else if (take) begin
          if (rptr_q == len_q) begin
`ifdef DCMI_PACK_CSUM_EN
            mdata_d = csum_sum;
            state_d = StCsum;
`else
            fin = 1'b1;
`endif
          end else begin
            mdata_d = ram_rdata;
            rptr_d  = rptr_q + 1'b1;
          end
        end
      end

`ifdef DCMI_PACK_CSUM_EN
      StCsum: begin
        if (reload) begin
          mdata_d = csum_q;
        end else if (take) begin
          fin = 1'b1;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    if (fin) begin
      state_d  = StIdle;
      dreq_d   = 1'b0;
      busy_d   = 1'b0;
      mdata_d  = MdataIdle;
      mvalid_d = 1'b0;
      count_d  = '0;
      rptr_d   = '0;
      wptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      count_q  <= '0;
      len_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      mdata_q  <= MdataIdle;
      mvalid_q <= 1'b0;
      dreq_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef DCMI_PACK_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      dreq_q   <= dreq_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
`ifdef DCMI_PACK_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign bus.mdata = mdata_q;
  assign bus.dreq  = dreq_q;
  assign bus.busy  = busy_q;
  assign bus.ovf   = ovf_q;

endmodule
